freelist_ckpt_ctrl: RTL and testbench
=====================================

# freelist_ckpt_ctrl

Branch-checkpoint controller for `freelist_int`. Snapshots the integer free list when a branch is renamed. Keeps snapshots coherent with commit-time frees. On a mispredict, drives `freelist_int`'s `recover`/`recover_fl` pair and squashes the mispredicted checkpoint and all younger ones. Sits in the frontend beside rename, between the branch unit's resolve bus and the free list.

## Interface
- `CKPT_NUM`, default 4: number of checkpoint slots; must be a power of two.
- `TAG_W`, default $clog2(CKPT_NUM): checkpoint tag width.
- `clock`  in  1  — single clock.
- `reset`  in  1  — synchronous, active-high.
- `ckpt_req`  in  1  — rename has one branch this cycle needing a snapshot.
- `ckpt_fl`  in  `PRF_INT_SIZE`  — free-list state after this cycle's allocations (1 = busy).
- `ckpt_grant`  out  1  — snapshot taken this cycle (combinational).
- `ckpt_tag`  out  TAG_W  — tag assigned to the granted branch, equal to tail.
- `ckpt_full`  out  1  — count == CKPT_NUM.
- `resolve_valid`  in  1  — branch resolution.
- `resolve_tag`  in  TAG_W.
- `resolve_mispredict`  in  1.
- `prf_replace_valid`  in  `RENAME_WIDTH` — commit-time frees, same bus as `freelist_int`.
- `prf_replace`  in  `RENAME_WIDTH` x `PRF_INT_INDEX_SIZE`.
- `flush`  in  1  — exception or full pipeline flush; drop all checkpoints.
- `recover`  out  1  — registered, one-cycle pulse to `freelist_int`.
- `recover_fl`  out  `PRF_INT_SIZE` — snapshot to restore; valid while `recover` is high.
- `recover_tag`  out  TAG_W — tag being recovered, for debug and ROB.

## Operation
- Storage is a circular buffer of CKPT_NUM entries. Each entry holds `valid`, `done`, and `snap[PRF_INT_SIZE]`. Pointers `head` and `tail` are TAG_W wide and wrap modulo CKPT_NUM. `count` is TAG_W+1 wide, range 0..CKPT_NUM.
- Free mask: `fmask` = OR over i of `prf_replace_valid[i]` ? onehot(`prf_replace[i]`) : 0. Each cycle, `snap &= ~fmask` for every valid entry.
- Allocate: `ckpt_grant = ckpt_req & !ckpt_full & !mispredict_now & !flush`.
  - On grant: `snap[tail] <= ckpt_fl & ~fmask`, set valid, clear done, `tail++`, `count++`.
  - There is no bypass from a same-cycle head retire when full.
- Correct resolve: `resolve_valid & !resolve_mispredict` to a valid tag sets `done[tag]`.
- Retire: if `head` is valid and done, clear valid and advance `head` by 1. At most one retire per cycle.
- Mispredict (`mispredict_now = resolve_valid & resolve_mispredict & valid[resolve_tag]`):
  - Load `rec_snap_q <= snap[tag] & ~fmask` and `recover_tag <= tag`, and set `recover` for the next cycle.
  - Invalidate `tag` and every younger entry up to `tail-1`. Set `tail <= tag`.
  - Set `count <= (tag - head) mod CKPT_NUM`, minus 1 if head retires this cycle. If `tag == head`, count becomes 0.
- `recover_fl = rec_snap_q & ~fmask`. Frees arriving in the recover cycle are masked in combinationally, because `freelist_int` drops its own `prf_replace` update when `recover` is high.
- Resolves to invalid (squashed) tags are ignored.
- `flush` clears all valid bits, `head = tail = count = 0`. It does not assert `recover`; the backend restores the free list by other means.
- FSM states:
  - NORMAL → RECOVER on `mispredict_now & !flush`.
  - RECOVER → NORMAL unconditionally after 1 cycle.
  - RECOVER → RECOVER if another valid mispredict arrives in the RECOVER cycle. Such a mispredict must belong to an older branch; it wins and re-arms.
  - `recover` = (state == RECOVER).
- Priority: reset > flush > mispredict > grant/resolve/retire.

## Timing
- Reset values: `recover` 0, `recover_fl` 0, `recover_tag` 0, `ckpt_grant` 0, `ckpt_tag` 0, `ckpt_full` 0. All entries invalid, state NORMAL.
- Grant is same-cycle combinational. The snapshot becomes visible one cycle after grant.
- Mispredict at cycle N → `recover` high at N+1 for exactly one cycle. `ckpt_grant` is 0 in cycle N. It is not forced low in N+1; rename is stalled externally.
- `done` set at cycle N → head retire possible at N+1.
- Reset mid-recovery: `recover` is 0 in the next cycle.

## Structure
- `CKPT_NUM`, the `ckpt_tag_t` typedef, and the `ckpt_entry_t` struct (valid, done, snap) belong in `micro_op.svh`.
- One sub-module, `prf_free_mask`: combinational `RENAME_WIDTH`-to-one-hot OR decoder producing `fmask`. It is reusable by the future fp checkpoint controller.

## Test plan
- Reset, then 4 granted reqs with `ckpt_fl` = 0x…0F/0x…1F/0x…3F/0x…7F → tags 0,1,2,3. `ckpt_full`=1. A 5th req gets `ckpt_grant`=0.
- Grant tag 0 with snap 0x…0F. Commit frees p2 two cycles later. Mispredict tag 0 → next cycle `recover`=1, `recover_fl`=0x…0B, `recover_tag`=0, count=0.
- Tags 0–3 live, mispredict tag 1 → tags 1–3 invalid, `tail`=1, count=1. A later resolve on tag 2 has no effect.
- Correct resolve of tag 1 then tag 0 (out of order) → head retires 0 then 1 on consecutive cycles; count 2→1→0.
- Mispredict at N, free of p5 at N+1 → `recover_fl[5]`=0 during the recover cycle.
- `flush` together with a mispredict → no `recover` pulse, count=0. Next req receives tag 0.

Source files
------------

// File: rtl/freelist_ckpt_ctrl_pkg.sv
// Shared types and sizes for the integer free-list checkpoint controller.
package freelist_ckpt_ctrl_pkg;

    localparam int CKPT_NUM           = 4;
    localparam int TAG_W              = $clog2(CKPT_NUM);
    localparam int PRF_INT_SIZE       = 32;
    localparam int PRF_INT_INDEX_SIZE = $clog2(PRF_INT_SIZE);
    localparam int RENAME_WIDTH       = 2;

    typedef logic [TAG_W-1:0]        ckpt_tag_t;
    typedef logic [PRF_INT_SIZE-1:0] prf_vec_t;

    // One checkpoint slot: liveness, resolved-correct flag and the busy-map snapshot.
    typedef struct packed {
        logic     valid;
        logic     done;
        prf_vec_t snap;
    } ckpt_entry_t;

    typedef enum logic {
        ST_NORMAL  = 1'b0,
        ST_RECOVER = 1'b1
    } ckpt_state_e;

endpackage

// File: rtl/freelist_ckpt_ctrl_prf_free_mask.sv
// Turns the commit-time free bus into a one-hot OR mask over the physical register file.
module prf_free_mask
    import freelist_ckpt_ctrl_pkg::*;
#(
    parameter int WIDTH = RENAME_WIDTH,
    parameter int SIZE  = PRF_INT_SIZE,
    parameter int IDX_W = PRF_INT_INDEX_SIZE
) (
    input  logic [WIDTH-1:0] prf_valid_i,
    input  logic [IDX_W-1:0] prf_idx_i [WIDTH],
    output logic [SIZE-1:0]  fmask_o
);

    // OR together one bit per valid free lane.
    always_comb begin
        // NOTE: combinational logic uses blocking '=' so later lanes see earlier updates.
        fmask_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (prf_valid_i[i]) begin
                fmask_o[prf_idx_i[i]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/freelist_ckpt_ctrl.sv
// Branch checkpoint controller: snapshots the integer free list per branch,
// keeps snapshots coherent with commit frees, and drives free-list recovery.
module freelist_ckpt_ctrl
    import freelist_ckpt_ctrl_pkg::*;
#(
    parameter int CKPT_NUM = freelist_ckpt_ctrl_pkg::CKPT_NUM,  // must be a power of two
    parameter int TAG_W    = $clog2(CKPT_NUM)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          ckpt_req,
    input  logic [PRF_INT_SIZE-1:0]       ckpt_fl,
    output logic                          ckpt_grant,
    output logic [TAG_W-1:0]              ckpt_tag,
    output logic                          ckpt_full,
    input  logic                          resolve_valid,
    input  logic [TAG_W-1:0]              resolve_tag,
    input  logic                          resolve_mispredict,
    input  logic [RENAME_WIDTH-1:0]       prf_replace_valid,
    input  logic [PRF_INT_INDEX_SIZE-1:0] prf_replace [RENAME_WIDTH],
    input  logic                          flush,
    output logic                          recover,
    output logic [PRF_INT_SIZE-1:0]       recover_fl,
    output logic [TAG_W-1:0]              recover_tag
);

    ckpt_entry_t       entries_q [CKPT_NUM];
    ckpt_entry_t       entries_d [CKPT_NUM];
    logic [TAG_W-1:0]  head_q, head_d;
    logic [TAG_W-1:0]  tail_q, tail_d;
    logic [TAG_W:0]    count_q, count_d;
    prf_vec_t          rec_snap_q, rec_snap_d;
    logic [TAG_W-1:0]  rec_tag_q, rec_tag_d;
    ckpt_state_e       state_q, state_d;

    prf_vec_t          fmask;
    logic              mispredict_now;
    logic              resolve_ok;
    logic              retire;
    logic              grant;
    logic [TAG_W-1:0]  tag_age;

    prf_free_mask #(
        .WIDTH (RENAME_WIDTH),
        .SIZE  (PRF_INT_SIZE),
        .IDX_W (PRF_INT_INDEX_SIZE)
    ) u_free_mask (
        .prf_valid_i (prf_replace_valid),
        .prf_idx_i   (prf_replace),
        .fmask_o     (fmask)
    );

    // Resolves to squashed slots are dropped by qualifying with the slot's valid bit.
    assign mispredict_now = resolve_valid & resolve_mispredict & entries_q[resolve_tag].valid;
    assign resolve_ok     = resolve_valid & ~resolve_mispredict & entries_q[resolve_tag].valid;
    // A head that is itself being squashed does not also retire.
    assign retire         = entries_q[head_q].valid & entries_q[head_q].done
                            & ~(mispredict_now && (resolve_tag == head_q));
    assign ckpt_full      = (count_q == (TAG_W+1)'(CKPT_NUM));
    assign grant          = ckpt_req & ~ckpt_full & ~mispredict_now & ~flush & ~reset;
    assign tag_age        = resolve_tag - head_q;
    assign ckpt_grant     = grant;
    assign ckpt_tag       = tail_q;

    // Next state of the checkpoint ring: flush, then mispredict, then normal traffic.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves a latch behind.
        entries_d  = entries_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        rec_snap_d = rec_snap_q;
        rec_tag_d  = rec_tag_q;

        for (int i = 0; i < CKPT_NUM; i++) begin
            entries_d[i].snap = entries_q[i].snap & ~fmask;
        end

        if (flush) begin
            for (int i = 0; i < CKPT_NUM; i++) begin
                entries_d[i].valid = 1'b0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else if (mispredict_now) begin
            rec_snap_d = entries_q[resolve_tag].snap & ~fmask;
            rec_tag_d  = resolve_tag;
            // Squash the mispredicted slot and everything younger (age measured from head).
            for (int i = 0; i < CKPT_NUM; i++) begin
                if (TAG_W'(TAG_W'(i) - head_q) >= tag_age) begin
                    entries_d[i].valid = 1'b0;
                end
            end
            if (retire) begin
                entries_d[head_q].valid = 1'b0;
                head_d = head_q + 1'b1;
            end
            tail_d  = resolve_tag;
            count_d = {1'b0, tag_age} - {{TAG_W{1'b0}}, retire};
        end else begin
            if (resolve_ok) begin
                entries_d[resolve_tag].done = 1'b1;
            end
            if (retire) begin
                entries_d[head_q].valid = 1'b0;
                head_d = head_q + 1'b1;
            end
            if (grant) begin
                entries_d[tail_q] = '{valid: 1'b1, done: 1'b0, snap: ckpt_fl & ~fmask};
                tail_d = tail_q + 1'b1;
            end
            count_d = count_q + {{TAG_W{1'b0}}, grant} - {{TAG_W{1'b0}}, retire};
        end
    end

    // Ring storage, pointers and recovery payload registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: only control bits are reset; snapshot payload is don't-care while invalid.
            for (int i = 0; i < CKPT_NUM; i++) begin
                entries_q[i].valid <= 1'b0;
                entries_q[i].done  <= 1'b0;
            end
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            rec_snap_q <= '0;
            rec_tag_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking '<=' so all flops update together.
            entries_q  <= entries_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            rec_snap_q <= rec_snap_d;
            rec_tag_q  <= rec_tag_d;
        end
    end

    // Recovery FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_NORMAL;
        end else begin
            state_q <= state_d;
        end
    end

    // RECOVER lasts one cycle unless a fresh mispredict re-arms it; flush never recovers.
    always_comb begin
        state_d = ST_NORMAL;
        if (mispredict_now && !flush) begin
            state_d = ST_RECOVER;
        end
    end

    // Recovery outputs; same-cycle frees are masked into the restored map.
    always_comb begin
        recover     = (state_q == ST_RECOVER);
        recover_fl  = rec_snap_q & ~fmask;
        recover_tag = rec_tag_q;
    end

endmodule

// File: tb/tb_freelist_ckpt_ctrl.sv
// Randomized self-checking bench for freelist_ckpt_ctrl with a queue-based reference model.
module tb_freelist_ckpt_ctrl;
    import freelist_ckpt_ctrl_pkg::*;

    localparam int N = CKPT_NUM;

    logic                          clock;
    logic                          reset;
    logic                          ckpt_req;
    logic [PRF_INT_SIZE-1:0]       ckpt_fl;
    logic                          ckpt_grant;
    logic [TAG_W-1:0]              ckpt_tag;
    logic                          ckpt_full;
    logic                          resolve_valid;
    logic [TAG_W-1:0]              resolve_tag;
    logic                          resolve_mispredict;
    logic [RENAME_WIDTH-1:0]       prf_replace_valid;
    logic [PRF_INT_INDEX_SIZE-1:0] prf_replace [RENAME_WIDTH];
    logic                          flush;
    logic                          recover;
    logic [PRF_INT_SIZE-1:0]       recover_fl;
    logic [TAG_W-1:0]              recover_tag;

    freelist_ckpt_ctrl dut (
        .clock              (clock),
        .reset              (reset),
        .ckpt_req           (ckpt_req),
        .ckpt_fl            (ckpt_fl),
        .ckpt_grant         (ckpt_grant),
        .ckpt_tag           (ckpt_tag),
        .ckpt_full          (ckpt_full),
        .resolve_valid      (resolve_valid),
        .resolve_tag        (resolve_tag),
        .resolve_mispredict (resolve_mispredict),
        .prf_replace_valid  (prf_replace_valid),
        .prf_replace        (prf_replace),
        .flush              (flush),
        .recover            (recover),
        .recover_fl         (recover_fl),
        .recover_tag        (recover_tag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: live checkpoints in program order, oldest first.
    typedef struct {
        int                      tag;
        bit                      done;
        logic [PRF_INT_SIZE-1:0] snap;
    } m_ent_t;

    m_ent_t                  mq[$];
    int                      m_tail     = 0;
    bit                      m_rec      = 0;
    logic [PRF_INT_SIZE-1:0] m_rec_snap = '0;
    int                      m_rec_tag  = 0;
    bit                      m_grant    = 0;

    function automatic int m_find(input int tag);
        foreach (mq[i]) if (mq[i].tag == tag) return i;
        return -1;
    endfunction

    function automatic logic [PRF_INT_SIZE-1:0] m_fmask();
        logic [PRF_INT_SIZE-1:0] m = '0;
        for (int i = 0; i < RENAME_WIDTH; i++)
            if (prf_replace_valid[i]) m = m | (PRF_INT_SIZE'(1) << prf_replace[i]);
        return m;
    endfunction

    // Drive one cycle of inputs at negedge, then check every output against the model.
    task automatic drive(input logic rq, input logic [PRF_INT_SIZE-1:0] fl,
                         input logic rv, input logic [TAG_W-1:0] rt, input logic rm,
                         input logic [RENAME_WIDTH-1:0] pv,
                         input logic [PRF_INT_INDEX_SIZE-1:0] p0,
                         input logic [PRF_INT_INDEX_SIZE-1:0] p1,
                         input logic fs, input logic rs);
        bit e_mp;
        @(negedge clock);
        ckpt_req = rq; ckpt_fl = fl;
        resolve_valid = rv; resolve_tag = rt; resolve_mispredict = rm;
        prf_replace_valid = pv; prf_replace[0] = p0; prf_replace[1] = p1;
        flush = fs; reset = rs;
        #1;
        e_mp    = rv && rm && (m_find(int'(rt)) >= 0);
        m_grant = rq && (mq.size() != N) && !e_mp && !fs && !rs;
        check_eq("ckpt_grant",  ckpt_grant,  m_grant);
        check_eq("ckpt_full",   ckpt_full,   mq.size() == N);
        check_eq("ckpt_tag",    ckpt_tag,    m_tail);
        check_eq("recover",     recover,     m_rec);
        check_eq("recover_fl",  recover_fl,  m_rec_snap & ~m_fmask());
        check_eq("recover_tag", recover_tag, m_rec_tag);
    endtask

    // Advance the model across the rising edge using the inputs still being driven.
    task automatic step();
        logic [PRF_INT_SIZE-1:0] fm;
        int  idx;
        bit  retire_now;
        @(posedge clock);
        fm = m_fmask();
        if (reset) begin
            mq.delete(); m_tail = 0; m_rec = 0; m_rec_snap = '0; m_rec_tag = 0;
        end else if (flush) begin
            mq.delete(); m_tail = 0; m_rec = 0;
        end else begin
            foreach (mq[i]) mq[i].snap = mq[i].snap & ~fm;
            idx = (resolve_valid && resolve_mispredict) ? m_find(int'(resolve_tag)) : -1;
            if (idx >= 0) begin
                m_rec = 1; m_rec_snap = mq[idx].snap; m_rec_tag = int'(resolve_tag);
                while (mq.size() > idx) void'(mq.pop_back());
                if (idx > 0 && mq[0].done) void'(mq.pop_front());
                m_tail = int'(resolve_tag);
            end else begin
                m_rec = 0;
                retire_now = (mq.size() > 0) && mq[0].done;
                idx = (resolve_valid && !resolve_mispredict) ? m_find(int'(resolve_tag)) : -1;
                if (idx >= 0) mq[idx].done = 1;
                if (retire_now) void'(mq.pop_front());
                if (m_grant) begin
                    mq.push_back('{tag: m_tail, done: 1'b0, snap: ckpt_fl & ~fm});
                    m_tail = (m_tail + 1) % N;
                end
            end
        end
    endtask

    task automatic idle();
        drive(0, '0, 0, '0, 0, '0, '0, '0, 0, 0);
    endtask

    task automatic do_reset();
        drive(0, '0, 0, '0, 0, '0, '0, '0, 0, 1); step();
    endtask

    initial begin
        reset = 1; ckpt_req = 0; ckpt_fl = '0; resolve_valid = 0; resolve_tag = '0;
        resolve_mispredict = 0; prf_replace_valid = '0; prf_replace[0] = '0;
        prf_replace[1] = '0; flush = 0;

        // Reset values.
        do_reset();
        idle();
        check_eq("rst_recover",     recover,     0);
        check_eq("rst_recover_fl",  recover_fl,  0);
        check_eq("rst_recover_tag", recover_tag, 0);
        check_eq("rst_tag",         ckpt_tag,    0);
        check_eq("rst_full",        ckpt_full,   0);
        step();

        // Fill all four slots, fifth request refused.
        for (int i = 0; i < N; i++) begin
            drive(1, (32'h1F << i) >> 1 | 32'h0F, 0, '0, 0, '0, '0, '0, 0, 0);
            check_eq("fill_grant", ckpt_grant, 1);
            check_eq("fill_tag",   ckpt_tag,   i);
            step();
        end
        drive(1, 32'hFF, 0, '0, 0, '0, '0, '0, 0, 0);
        check_eq("full_flag",  ckpt_full,  1);
        check_eq("full_grant", ckpt_grant, 0);
        step();

        // Mispredict tag 1 squashes 1..3; a later resolve on tag 2 is ignored.
        drive(0, '0, 1, 2'd1, 1, '0, '0, '0, 0, 0); step();
        drive(0, '0, 1, 2'd2, 1, '0, '0, '0, 0, 0);
        check_eq("mp1_recover", recover,     1);
        check_eq("mp1_rtag",    recover_tag, 1);
        check_eq("mp1_tail",    ckpt_tag,    1);
        check_eq("mp1_snap",    recover_fl,  32'h1F);
        step();
        idle();
        check_eq("squashed_resolve", recover, 0);
        step();

        // Snapshot 0x0F, free p2 two cycles later, mispredict tag 0.
        do_reset();
        drive(1, 32'h0F, 0, '0, 0, '0, '0, '0, 0, 0); step();
        idle(); step();
        drive(0, '0, 0, '0, 0, 2'b01, 5'd2, '0, 0, 0); step();
        drive(0, '0, 1, 2'd0, 1, '0, '0, '0, 0, 0); step();
        idle();
        check_eq("mp0_recover", recover,     1);
        check_eq("mp0_fl",      recover_fl,  32'h0B);
        check_eq("mp0_rtag",    recover_tag, 0);
        step();
        drive(1, 32'h3F, 0, '0, 0, '0, '0, '0, 0, 0);
        check_eq("mp0_next_tag", ckpt_tag, 0);
        step();

        // Free of p5 in the recover cycle is masked into recover_fl.
        drive(0, '0, 1, 2'd0, 1, '0, '0, '0, 0, 0); step();
        drive(0, '0, 0, '0, 0, 2'b10, '0, 5'd5, 0, 0);
        check_eq("p5_recover", recover,    1);
        check_eq("p5_fl",      recover_fl, 32'h1F);
        step();

        // Out-of-order correct resolves, then flush together with a mispredict.
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h7, 0, '0, 0, '0, '0, '0, 0, 0); step();
        end
        drive(0, '0, 1, 2'd1, 0, '0, '0, '0, 0, 0); step();
        drive(0, '0, 1, 2'd0, 0, '0, '0, '0, 0, 0); step();
        idle(); step();
        idle(); step();
        drive(0, '0, 1, 2'd2, 1, '0, '0, '0, 1, 0); step();
        drive(1, 32'h3, 0, '0, 0, '0, '0, '0, 0, 0);
        check_eq("flush_no_recover", recover,    0);
        check_eq("flush_grant",      ckpt_grant, 1);
        check_eq("flush_tag",        ckpt_tag,   0);
        step();

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(99) < 60, $urandom,
                  $urandom_range(99) < 40, TAG_W'($urandom_range(N-1)),
                  $urandom_range(99) < 25, RENAME_WIDTH'($urandom),
                  PRF_INT_INDEX_SIZE'($urandom_range(PRF_INT_SIZE-1)),
                  PRF_INT_INDEX_SIZE'($urandom_range(PRF_INT_SIZE-1)),
                  $urandom_range(49) == 0, $urandom_range(199) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
